odo_sbox6_seq: RTL and testbench
================================

Name: odo_sbox6_seq

Overview:
- Time-multiplexed substitution-layer sequencer for the Odo datapath.
- Accepts a word of LANES packed 6-bit lanes and feeds the lanes one per cycle through a single shared external 6-bit small S-box ROM. The ROM has a registered read with 1-cycle latency.
- Reassembles the substituted lanes and presents the result on a valid/ready output.
- Lets one small-S-box instance serve a full substitution round, trading throughput for area.

Parameters:
- LANES, 10, number of 6-bit lanes per word; legal range 1..64.
- CW, $clog2(LANES+1), lane counter width; derived, not overridden.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  input word valid
- in_ready  output  1  block can accept a word
- in_data  input  6*LANES  packed lanes; lane i = bits [6i+5:6i]
- out_valid  output  1  substituted word valid
- out_ready  input  1  consumer accepts word
- out_data  output  6*LANES  substituted lanes, same packing
- sbox_addr  output  6  address to shared S-box ROM
- sbox_data  input  6  ROM output; value for address presented one edge earlier
- busy  output  1  high in RUN or DONE

Behaviour:
- Reset (rst_n low, async):
  - state=IDLE, lane counter=0, issue-pending flag=0.
  - Input capture register=0, out_data=0.
  - Outputs: in_ready=1, out_valid=0, busy=0, sbox_addr=0.
- Reset mid-operation aborts the word silently; no partial output is ever presented.
- States:
  - IDLE: in_ready=1. On in_valid&in_ready, capture in_data, cnt=0, go to RUN. out_data keeps its last value.
  - RUN: in_ready=0. sbox_addr is combinational: lane cnt of the capture register.
    - Each edge: cnt increments; issue-pending flag <= 1 with issue index <= cnt.
    - When the flag is set, sbox_data is written into out_data lane (issue index).
    - After lane LANES-1 is issued, cnt stops issuing; the flag clears after the final capture.
    - Go to DONE on the edge that captures lane LANES-1.
  - DONE: out_valid=1, out_data stable. On out_ready go to IDLE; out_valid drops the next cycle.
- Latency: input handshake at edge E0.
  - Lane k is issued (sbox_addr stable) during cycle E(k)..E(k+1) and captured at E(k+2).
  - out_valid goes high after E(LANES+1): 11 cycles for LANES=10.
- Throughput: one word per LANES+3 edges with out_ready held high, since IDLE takes one cycle.
- sbox_addr=0 outside RUN; ROM reads in IDLE/DONE are harmless and ignored.
- out_data is written only in RUN; it is never modified while out_valid=1.
- Input backpressure: in_data is sampled only at the handshake; later changes have no effect.
- Output backpressure: DONE holds indefinitely; no new input is accepted.
- in_valid asserted during RUN/DONE is ignored (in_ready=0); the source must hold it.
- LANES=1: single issue, out_valid after E2.
- Counter never exceeds LANES; no wrap-around occurs.

Test Plan:
- Reset release, in_data=0, LANES=10, out_ready=1 -> out_valid high exactly 11 cycles after acceptance; out_data=60'h79E79E79E79E79E (every lane 0x1e).
- Lane i = i for i=0..9 -> out lanes 0..9 = 1e,30,26,28,3d,37,19,3e,38,13. Check sbox_addr sequence 0..9 on consecutive cycles.
- in_data all ones, out_ready low for 5 cycles after out_valid -> out_valid held, out_data stable (every lane 0x2b), in_ready=0, busy=1 throughout; handshake then returns to IDLE.
- Two words back-to-back with in_valid held and out_ready=1 -> second accepted 13 edges after the first; results in order, no lane mixing.
- rst_n pulsed low while cnt=4 in RUN -> out_valid=0, out_data=0, in_ready=1 immediately. Next word processes correctly with full 11-cycle latency.
- in_data changed every cycle during RUN -> result reflects only the captured word.

Source files
------------

// File: rtl/odo_sbox6_seq.sv
// rtl/odo_sbox6_seq.sv - time-multiplexed 6-bit S-box layer sequencer
// Streams LANES packed lanes one per cycle through a shared registered-read ROM.
module odo_sbox6_seq #(
  parameter int LANES = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [6*LANES-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [6*LANES-1:0] out_data,
  output logic [5:0]         sbox_addr,
  input  logic [5:0]         sbox_data,
  output logic               busy
);

  localparam int CW = $clog2(LANES + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(LANES);
  localparam logic [CW-1:0] LAST_IDX = CW'(LANES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [CW-1:0]      idx_q, idx_d;
  logic               pend_q, pend_d;
  logic [6*LANES-1:0] cap_q, cap_d;
  logic [6*LANES-1:0] out_data_q, out_data_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;
  logic [5:0]         sbox_addr_c;

  // Address is combinational so the ROM registers lane cnt on the coming edge.
  always_comb begin
    sbox_addr_c = '0;
    if (state_q == S_RUN) begin
      for (int i = 0; i < LANES; i++) begin
        if (cnt_q == CW'(i)) sbox_addr_c = cap_q[6*i +: 6];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    pend_d     = pend_q;
    cap_d      = cap_q;
    out_data_d = out_data_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          cap_d   = in_data;
          cnt_d   = '0;
          pend_d  = 1'b0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (cnt_q != LAST_CNT) begin
          cnt_d  = cnt_q + 1'b1;
          idx_d  = cnt_q;
          pend_d = 1'b1;
        end else begin
          pend_d = 1'b0;
        end
        // ROM data in this cycle belongs to the lane issued one cycle earlier.
        if (pend_q) begin
          for (int i = 0; i < LANES; i++) begin
            if (idx_q == CW'(i)) out_data_d[6*i +: 6] = sbox_data;
          end
          if (idx_q == LAST_IDX) state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      pend_q      <= 1'b0;
      cap_q       <= '0;
      out_data_q  <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      pend_q      <= pend_d;
      cap_q       <= cap_d;
      out_data_q  <= out_data_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;
  assign sbox_addr = sbox_addr_c;

endmodule

// File: tb/tb_odo_sbox6_seq.sv
// tb/tb_odo_sbox6_seq.sv - self-checking bench for odo_sbox6_seq
module tb_odo_sbox6_seq;
  localparam int L = 10;
  localparam int W = 6 * L;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         out_ready;
  logic         in_ready, out_valid, busy;
  logic [W-1:0] out_data;
  logic [5:0]   sbox_addr;
  logic [5:0]   sbox_data = '0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc = 0;

  logic rnd_ready = 1'b0;
  logic rnd_bit = 1'b1;
  logic or_fixed = 1'b1;
  logic [5:0] rom [64];

  odo_sbox6_seq #(.LANES(L)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .sbox_addr(sbox_addr), .sbox_data(sbox_data), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) sbox_data <= rom[sbox_addr];
  always @(posedge clk) begin
    #1;
    rnd_bit = 1'($urandom % 2);
  end
  always_comb out_ready = rnd_ready ? rnd_bit : or_fixed;

  function automatic logic [W-1:0] subst(input logic [W-1:0] d);
    logic [W-1:0] r;
    for (int i = 0; i < L; i++) r[6*i +: 6] = rom[d[6*i +: 6]];
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h time=%0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: a word is busy from acceptance until its output handshake.
  logic         m_busy = 1'b0, m_valid = 1'b0;
  int           m_t = 0;
  logic [W-1:0] m_cap = '0, m_out = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy  <= 1'b0;
      m_valid <= 1'b0;
      m_t     <= 0;
      m_cap   <= '0;
      m_out   <= '0;
    end else if (!m_busy) begin
      if (in_valid) begin
        m_busy <= 1'b1;
        m_t    <= 0;
        m_cap  <= in_data;
      end
    end else if (m_valid) begin
      if (out_ready) begin
        m_busy  <= 1'b0;
        m_valid <= 1'b0;
      end
    end else begin
      m_t <= m_t + 1;
      if (m_t + 1 == L + 1) begin
        m_valid <= 1'b1;
        m_out   <= subst(m_cap);
      end
    end
  end

  always @(negedge clk) begin
    logic [5:0] ea;
    if (rst_n) begin
      ea = (m_busy && !m_valid && m_t < L) ? m_cap[6*m_t +: 6] : 6'd0;
      chk("in_ready", 64'(in_ready), 64'(!m_busy));
      chk("out_valid", 64'(out_valid), 64'(m_valid));
      chk("busy", 64'(busy), 64'(m_busy));
      chk("sbox_addr", 64'(sbox_addr), 64'(ea));
      if (!(m_busy && !m_valid)) chk("out_data", 64'(out_data), 64'(m_out));
    end
  end

  task automatic send(input logic [W-1:0] d, input bit keep);
    bit ok = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
      end
    end
    if (!keep) in_valid = 1'b0;
    acc = cyc;
    if (!ok) chk("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_valid(output int lat);
    bit ok = 1'b0;
    lat = -1;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (out_valid) begin
        ok = 1'b1;
        lat = cyc - acc;
      end
    end
    if (!ok) chk("valid_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    int lat, c1;
    logic [W-1:0] w, e;
    logic [5:0] t2 [10];
    t2 = '{6'h1e, 6'h30, 6'h26, 6'h28, 6'h3d, 6'h37, 6'h19, 6'h3e, 6'h38, 6'h13};
    for (int a = 0; a < 64; a++) rom[a] = 6'((a * 23 + 17) % 64);
    for (int a = 0; a < 10; a++) rom[a] = t2[a];
    rom[63] = 6'h2b;

    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_sbox_addr", 64'(sbox_addr), 64'd0);
    @(negedge clk) rst_n = 1'b1;

    // all-zero word
    send('0, 1'b0);
    wait_valid(lat);
    chk("t1_latency", 64'(lat), 64'd11);
    chk("t1_data", 64'(out_data), 64'h79E79E79E79E79E);
    repeat (2) @(posedge clk);
    #1;

    // lane i = i, address sequence 0..9
    for (int i = 0; i < L; i++) w[6*i +: 6] = 6'(i);
    send(w, 1'b0);
    for (int k = 0; k < L; k++) begin
      @(negedge clk);
      chk("t2_addr_seq", 64'(sbox_addr), 64'(k));
    end
    wait_valid(lat);
    for (int i = 0; i < L; i++) e[6*i +: 6] = t2[i];
    chk("t2_latency", 64'(lat), 64'd11);
    chk("t2_data", 64'(out_data), 64'(e));
    repeat (2) @(posedge clk);
    #1;

    // all ones with output backpressure
    or_fixed = 1'b0;
    send('1, 1'b0);
    wait_valid(lat);
    for (int i = 0; i < L; i++) e[6*i +: 6] = 6'h2b;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t3_hold_valid", 64'(out_valid), 64'd1);
      chk("t3_hold_data", 64'(out_data), 64'(e));
      chk("t3_hold_in_ready", 64'(in_ready), 64'd0);
      chk("t3_hold_busy", 64'(busy), 64'd1);
    end
    or_fixed = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t3_release_valid", 64'(out_valid), 64'd0);
    chk("t3_release_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    // back-to-back with in_valid held
    w = W'({$urandom(), $urandom()});
    send(w, 1'b1);
    c1 = acc;
    e = W'({$urandom(), $urandom()});
    send(e, 1'b0);
    chk("t4_gap", 64'(acc - c1), 64'd13);
    wait_valid(lat);
    chk("t4_second_data", 64'(out_data), 64'(subst(e)));
    repeat (3) @(posedge clk);
    #1;

    // reset mid-run at cnt=4
    send(W'({$urandom(), $urandom()}), 1'b0);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_out_valid", 64'(out_valid), 64'd0);
    chk("t5_out_data", 64'(out_data), 64'd0);
    chk("t5_in_ready", 64'(in_ready), 64'd1);
    chk("t5_busy", 64'(busy), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    w = W'({$urandom(), $urandom()});
    send(w, 1'b0);
    wait_valid(lat);
    chk("t5_latency", 64'(lat), 64'd11);
    chk("t5_data", 64'(out_data), 64'(subst(w)));
    repeat (2) @(posedge clk);
    #1;

    // in_data churns while the word is in flight
    or_fixed = 1'b0;
    w = W'({$urandom(), $urandom()});
    send(w, 1'b0);
    for (int k = 0; k < 14; k++) begin
      @(posedge clk);
      #1 in_data = W'({$urandom(), $urandom()});
    end
    @(negedge clk);
    chk("t6_valid", 64'(out_valid), 64'd1);
    chk("t6_data", 64'(out_data), 64'(subst(w)));
    or_fixed = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // randomized words with random output backpressure
    rnd_ready = 1'b1;
    for (int n = 0; n < 25; n++) begin
      repeat ($urandom % 3) @(posedge clk);
      #1;
      send(W'({$urandom(), $urandom()}), 1'b0);
    end
    repeat (40) @(posedge clk);
    rnd_ready = 1'b0;
    repeat (20) @(posedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
